// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 serial receiver with mid-bit sampling and a valid/ack holding register
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   input  logic       data_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   // The IDLE cycle that spots the falling edge counts as the first half-bit cycle.
   localparam logic [CW-1:0] MID_CNT  = CW'((CLKS_PER_BIT - 1) / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] clk_cnt, clk_cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shift, shift_nx;
   logic          rx_m, rx_s, armed;
   logic [1:0]    warm;
   logic          good_stop, bad_stop, load;

   // Arming waits until the synchronizer has flushed its preset ones, so a line
   // held low through reset is never mistaken for idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_m  <= 1'b1;
         rx_s  <= 1'b1;
         warm  <= 2'b00;
         armed <= 1'b0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         warm <= {warm[0], 1'b1};
         if (warm[1] && rx_s)
            armed <= 1'b1;
      end
   end

   always_comb begin
      state_nx   = state;
      clk_cnt_nx = clk_cnt;
      bit_idx_nx = bit_idx;
      shift_nx   = shift;
      good_stop  = 1'b0;
      bad_stop   = 1'b0;
      case (state)
         IDLE: begin
            clk_cnt_nx = '0;
            bit_idx_nx = '0;
            shift_nx   = '0;
            if (armed && !rx_s)
               state_nx = START;
         end
         START: begin
            if (clk_cnt == MID_CNT) begin
               clk_cnt_nx = '0;
               state_nx   = rx_s ? IDLE : DATA;
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         DATA: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_nx        = '0;
               shift_nx[bit_idx] = rx_s;
               if (bit_idx == LAST_BIT) begin
                  bit_idx_nx = '0;
                  state_nx   = STOP;
               end else begin
                  bit_idx_nx = bit_idx + 3'd1;
               end
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         STOP: begin
            if (clk_cnt == LAST_CNT) begin
               clk_cnt_nx = '0;
               good_stop  = rx_s;
               bad_stop   = !rx_s;
               state_nx   = CLEANUP;
            end else begin
               clk_cnt_nx = clk_cnt + 1'b1;
            end
         end
         CLEANUP: begin
            clk_cnt_nx = '0;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign load = good_stop && (!data_valid || data_ack);
   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         clk_cnt    <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state     <= state_nx;
         clk_cnt   <= clk_cnt_nx;
         bit_idx   <= bit_idx_nx;
         shift     <= shift_nx;
         frame_err <= bad_stop;
         if (load) begin
            data_out   <= shift;
            data_valid <= 1'b1;
         end else if (data_ack) begin
            data_valid <= 1'b0;
         end
         if (good_stop && data_valid && !data_ack)
            overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed bench for uart_rx_core at 16 clocks per bit
module tb_uart_rx_core;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       data_ack = 1'b0;
   logic [7:0] data_out;
   logic       data_valid, frame_err, overrun, busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   int rise_cyc = -1;
   int fe_cnt = 0;
   logic dv_q = 1'b0;

   uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk(clk), .reset(reset), .rx(rx), .data_ack(data_ack),
      .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (data_valid && !dv_q) rise_cyc <= cyc;
      dv_q <= data_valid;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      repeat (4) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      t0 = cyc;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) tick();
      end
      rx = stop;
      repeat (CPB) tick();
      rx = 1'b1;
      repeat (2 * CPB) tick();
   endtask

   initial begin
      tick();
      check("reset_data_out", {24'd0, data_out}, 32'h0);
      check("reset_valid", {31'd0, data_valid}, 32'd0);
      check("reset_frame_err", {31'd0, frame_err}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      repeat (6) tick();

      // Single frame and latency from the falling edge
      send_frame(8'hA5, 1'b1);
      check("a5_latency", rise_cyc - t0, 32'd154);
      check("a5_data", {24'd0, data_out}, 32'hA5);
      check("a5_valid", {31'd0, data_valid}, 32'd1);
      check("a5_frame_err", fe_cnt, 32'd0);
      check("a5_overrun", {31'd0, overrun}, 32'd0);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("a5_ack_clears", {31'd0, data_valid}, 32'd0);

      // Overrun: second good byte while the first is unconsumed
      send_frame(8'h3C, 1'b1);
      send_frame(8'hC3, 1'b1);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      check("ovr_keeps_old", {24'd0, data_out}, 32'h3C);
      check("ovr_valid", {31'd0, data_valid}, 32'd1);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;
      check("ovr_ack_valid", {31'd0, data_valid}, 32'd0);
      check("ovr_sticky", {31'd0, overrun}, 32'd1);

      // Framing error then a clean frame
      fe_cnt = 0;
      send_frame(8'h55, 1'b0);
      check("fe_pulse_count", fe_cnt, 32'd1);
      check("fe_valid", {31'd0, data_valid}, 32'd0);
      check("fe_data_kept", {24'd0, data_out}, 32'h3C);
      send_frame(8'h0F, 1'b1);
      check("fe_next_data", {24'd0, data_out}, 32'h0F);
      check("fe_next_valid", {31'd0, data_valid}, 32'd1);
      check("fe_no_new_err", fe_cnt, 32'd1);
      data_ack = 1'b1;
      tick();
      data_ack = 1'b0;

      // Short glitch on an idle line
      do_reset();
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      check("glitch_busy_seen", {31'd0, busy}, 32'd1);
      repeat (7) tick();
      check("glitch_busy_drop", {31'd0, busy}, 32'd0);
      repeat (20) tick();
      check("glitch_no_valid", {31'd0, data_valid}, 32'd0);

      // Reset in the middle of data bit 3 with the line low
      rx = 1'b0;
      repeat (CPB * 4 + 8) tick();
      reset = 1'b1;
      tick();
      check("midrst_valid", {31'd0, data_valid}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      repeat (2) tick();
      reset = 1'b0;
      repeat (40) tick();
      check("held_low_busy", {31'd0, busy}, 32'd0);
      check("held_low_valid", {31'd0, data_valid}, 32'd0);
      rx = 1'b1;
      repeat (20) tick();
      fe_cnt = 0;
      send_frame(8'h81, 1'b1);
      check("after_rst_data", {24'd0, data_out}, 32'h81);
      check("after_rst_valid", {31'd0, data_valid}, 32'd1);
      check("after_rst_fe", fe_cnt, 32'd0);

      // Ack coinciding with the second load
      do_reset();
      send_frame(8'h01, 1'b1);
      check("b2b_first", {24'd0, data_out}, 32'h01);
      fork
         send_frame(8'hFE, 1'b1);
         begin
            repeat (153) tick();
            data_ack = 1'b1;
            tick();
            data_ack = 1'b0;
         end
      join
      check("b2b_data", {24'd0, data_out}, 32'hFE);
      check("b2b_valid", {31'd0, data_valid}, 32'd1);
      check("b2b_overrun", {31'd0, overrun}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Serial receive end of the board's 8N1 asynchronous serial link.
- Converts the line back into parallel bytes for the `main` datapath: synchronizes the line, validates the start bit at mid-bit, samples data LSB-first, checks the stop bit.
- Presents each byte in a holding register with a valid/ack handshake.
- Runs on the 50 MHz system clock.

Parameters:
- CLKS_PER_BIT, 434, system clocks per serial bit (50 MHz / 115200); minimum 4.
- DATA_BITS, 8, data bits per frame (5..8); data_out is always 8 bits, unused MSBs are 0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- data_ack  input  1  consumer accepts the byte in data_out.
- data_out  output  8  last good received byte.
- data_valid  output  1  data_out holds an unconsumed byte.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun  output  1  sticky: a good byte arrived while data_valid=1 and no ack.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; state IDLE; counters 0.
  - Synchronizer flops preset to 1.
  - armed flag cleared.
- Synchronizer:
  - Two flops on rx produce rx_s; 2-cycle latency.
  - Only rx_s is used internally.
- armed flag:
  - Set on the first cycle rx_s=1 after reset.
  - IDLE ignores rx_s=0 until armed, so reset mid-frame never decodes a partial frame.
- Bit counter: clk_cnt runs 0..CLKS_PER_BIT-1; bit_idx runs 0..DATA_BITS-1.
- States:
  - IDLE: if armed and rx_s=0, go to START with clk_cnt=0.
  - START: count to (CLKS_PER_BIT-1)/2 (integer division).
    - At that count, rx_s=0: go to DATA, clk_cnt=0.
    - At that count, rx_s=1: glitch; return to IDLE with no output change.
  - DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit_idx] (LSB first).
    - After bit DATA_BITS-1, go to STOP; otherwise increment bit_idx.
  - STOP: count to CLKS_PER_BIT-1, then sample rx_s.
    - 1 = good frame; 0 = framing error.
    - Go to CLEANUP.
  - CLEANUP: one cycle, then IDLE. A new start bit is detectable the following cycle.
- Good frame, in the STOP sample cycle:
  - If data_valid=0, or data_ack=1 in the same cycle: load data_out, set data_valid=1.
  - If data_valid=1 and data_ack=0: set overrun=1; data_out keeps the old byte.
- Framing error: frame_err=1 for exactly the STOP sample cycle; data discarded; data_valid/data_out unchanged.
- Handshake:
  - data_valid clears on the edge after data_ack is sampled high with no simultaneous load.
  - data_ack while data_valid=0 is ignored.
  - overrun clears only on reset.
- Timing:
  - Mid-bit sampling; sample point of data bit k is (CLKS_PER_BIT-1)/2 + (k+1)*CLKS_PER_BIT cycles after the start edge reaches rx_s.
  - data_valid rises (CLKS_PER_BIT-1)/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the rx falling edge, plus 2 for the synchronizer.
- Tolerance: ±3% baud mismatch must decode correctly.
- Reset mid-operation:
  - Immediate return to IDLE with outputs cleared.
  - A held-low line is not a start until rx_s is first seen high.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (8N1) -> data_valid rises 2+7+9*16+1=154 cycles after the falling edge; data_out=0xA5; frame_err=0; overrun=0.
- Send 0x3C, no ack, then send 0xC3 -> overrun=1; data_out stays 0x3C. Then ack -> data_valid=0 one cycle later, overrun still 1.
- Send 0x55 with stop bit driven 0 -> frame_err pulses exactly 1 cycle; data_valid stays 0. Next frame 0x0F -> received correctly.
- 4-cycle low glitch on idle line -> returns to IDLE at mid-start check; no data_valid, busy drops within 10 cycles.
- Assert reset mid-bit 3 of a frame while rx=0, release with rx still low -> no byte decoded. Subsequent 0x81 after line idles high -> data_out=0x81.
- Back-to-back frames 0x01, 0xFE with ack pulsed on the same cycle as the second load -> data_out=0xFE, data_valid=1, overrun=0.
